// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam int DEF_TIMEOUT = 255;

  // Counter only has to reach TIMEOUT-1.
  function automatic int cnt_width(input int t);
    return (t < 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Winner select between the CPU and DMA requesters (round-robin or CPU-priority).
module mem_rr_pick
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic   i_c_req,
  input  logic   i_d_req,
  input  owner_t i_last,
  output owner_t o_owner,
  output logic   o_valid
);

  always_comb begin
    o_valid = i_c_req | i_d_req;
    if (i_c_req && i_d_req)
      o_owner = (FIXED_PRI || i_last == OWN_DMA) ? OWN_CPU : OWN_DMA;
    else if (i_d_req)
      o_owner = OWN_DMA;
    else
      o_owner = OWN_CPU;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the multicycle MIPS unified memory port between the CPU datapath
// and the DMA/program loader, one transaction at a time, with a watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_done,
  output logic              c_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  state_t            r_state, w_next;
  owner_t            r_owner, r_last, w_pick;
  logic              w_pick_vld;
  logic              w_timeout;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_c_rdata, r_d_rdata;

  mem_rr_pick #(.FIXED_PRI(FIXED_PRI != 0)) u_pick (
    .i_c_req (c_req),
    .i_d_req (d_req),
    .i_last  (r_last),
    .o_owner (w_pick),
    .o_valid (w_pick_vld)
  );

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_pick_vld) w_next = ST_BUSY;
      ST_BUSY: if (mem_ready || w_timeout) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    c_done = (r_state == ST_DONE) && (r_owner == OWN_CPU);
    d_done = (r_state == ST_DONE) && (r_owner == OWN_DMA);
    c_err  = c_done & r_err;
    d_err  = d_done & r_err;
  end

  // Requester inputs are captured once in IDLE; the memory side sees only the latched copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= OWN_CPU;
      r_last      <= OWN_DMA;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_c_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_pick_vld) begin
          r_owner     <= w_pick;
          r_last      <= w_pick;
          r_mem_req   <= 1'b1;
          r_mem_we    <= (w_pick == OWN_DMA) ? d_we    : c_we;
          r_mem_addr  <= (w_pick == OWN_DMA) ? d_addr  : c_addr;
          r_mem_wdata <= (w_pick == OWN_DMA) ? d_wdata : c_wdata;
          r_cnt       <= '0;
        end
        ST_BUSY: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b0;
            if (!r_mem_we) begin
              if (r_owner == OWN_DMA) r_d_rdata <= mem_rdata;
              else                    r_c_rdata <= mem_rdata;
            end
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            if (r_owner == OWN_DMA) r_d_rdata <= '0;
            else                    r_c_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign c_rdata   = r_c_rdata;
  assign d_rdata   = r_d_rdata;
  assign stall     = c_req & ~c_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: per-cycle vector table plus hand sequences for timeout, reset and ties.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        c_req, c_we, d_req, d_we, mem_ready;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata, mem_rdata;

  logic [31:0] a_c_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
  logic        a_c_done, a_c_err, a_d_done, a_d_err, a_mem_req, a_mem_we, a_stall;
  logic [31:0] b_c_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic        b_c_done, b_c_err, b_d_done, b_d_err, b_mem_req, b_mem_we, b_stall;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .FIXED_PRI(0)) u_a (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(a_c_rdata), .c_done(a_c_done), .c_err(a_c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(a_d_rdata), .d_done(a_d_done), .d_err(a_d_err),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(a_stall)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .FIXED_PRI(1)) u_b (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(b_c_rdata), .c_done(b_c_done), .c_err(b_c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(b_d_rdata), .d_done(b_d_done), .d_err(b_d_err),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(b_stall)
  );

  typedef struct {
    logic c_req, c_we; logic [31:0] c_addr, c_wdata;
    logic d_req, d_we; logic [31:0] d_addr, d_wdata;
    logic rdy; logic [31:0] rdata;
    logic e_mreq, e_mwe; logic [31:0] e_maddr, e_mwdata;
    logic e_cdone, e_cerr; logic [31:0] e_crdata;
    logic e_ddone, e_derr; logic [31:0] e_drdata;
    logic e_stall;
  } vec_t;

  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] RD = 32'h8C08_0004;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] DR = 32'hA5A5_0001;
  localparam logic        H  = 1'b1;
  localparam logic        L  = 1'b0;

  vec_t vt[16];
  int   n_run = 0;
  int   n_fail = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic apply(input vec_t v);
    c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    mem_ready = v.rdy; mem_rdata = v.rdata;
  endtask

  initial begin
    // c_req c_we c_addr c_wdata | d_req d_we d_addr d_wdata | rdy rdata || mreq mwe maddr mwdata | cdone cerr crdata | ddone derr drdata | stall
    vt[0]  = '{H,L,32'h40,Z, L,L,Z,Z,              L,Z,            L,L,Z,Z,           L,L,Z,  L,L,Z,  H};
    vt[1]  = '{H,L,32'h40,Z, L,L,Z,Z,              H,RD,           H,L,32'h40,Z,      L,L,Z,  L,L,Z,  H};
    vt[2]  = '{H,L,32'h40,Z, L,L,Z,Z,              L,Z,            L,L,32'h40,Z,      H,L,RD, L,L,Z,  L};
    vt[3]  = '{L,L,Z,Z,      L,L,Z,Z,              L,Z,            L,L,32'h40,Z,      L,L,RD, L,L,Z,  L};
    vt[4]  = '{L,L,Z,Z,      H,H,32'h100,DB,       L,Z,            L,L,32'h40,Z,      L,L,RD, L,L,Z,  L};
    vt[5]  = '{L,L,Z,Z,      H,H,32'h100,DB,       L,Z,            H,H,32'h100,DB,    L,L,RD, L,L,Z,  L};
    vt[6]  = '{L,L,Z,Z,      H,H,32'h200,32'h1111, L,Z,            H,H,32'h100,DB,    L,L,RD, L,L,Z,  L};
    vt[7]  = '{L,L,Z,Z,      H,H,32'h200,32'h1111, L,Z,            H,H,32'h100,DB,    L,L,RD, L,L,Z,  L};
    vt[8]  = '{L,L,Z,Z,      H,H,32'h200,32'h1111, H,32'h5555_5555,H,H,32'h100,DB,    L,L,RD, L,L,Z,  L};
    vt[9]  = '{L,L,Z,Z,      H,H,32'h200,32'h1111, L,Z,            L,H,32'h100,DB,    L,L,RD, H,L,Z,  L};
    vt[10] = '{L,L,Z,Z,      L,L,Z,Z,              H,32'h77,       L,H,32'h100,DB,    L,L,RD, L,L,Z,  L};
    vt[11] = '{L,L,Z,Z,      L,L,Z,Z,              H,32'h77,       L,H,32'h100,DB,    L,L,RD, L,L,Z,  L};
    vt[12] = '{L,L,Z,Z,      H,L,32'h300,Z,        H,32'h99,       L,H,32'h100,DB,    L,L,RD, L,L,Z,  L};
    vt[13] = '{L,L,Z,Z,      H,L,32'h300,Z,        H,DR,           H,L,32'h300,Z,     L,L,RD, L,L,Z,  L};
    vt[14] = '{L,L,Z,Z,      H,L,32'h300,Z,        H,32'hFFFF_FFFF,L,L,32'h300,Z,     L,L,RD, H,L,DR, L};
    vt[15] = '{L,L,Z,Z,      L,L,Z,Z,              L,Z,            L,L,32'h300,Z,     L,L,RD, L,L,DR, L};

    rst = 1; idle_in();
    repeat (2) @(posedge clk);
    #1; rst = 0;
    #1;
    chk1 ("reset mem_req", a_mem_req, 1'b0);
    chk32("reset mem_addr", a_mem_addr, 32'h0);
    chk1 ("reset c_done", a_c_done, 1'b0);
    chk1 ("reset d_done", a_d_done, 1'b0);
    chk32("reset c_rdata", a_c_rdata, 32'h0);
    chk1 ("reset stall", a_stall, 1'b0);

    for (int i = 0; i < 16; i++) begin
      apply(vt[i]);
      #1;
      chk1 ($sformatf("row%0d mem_req", i), a_mem_req, vt[i].e_mreq);
      chk1 ($sformatf("row%0d mem_we", i), a_mem_we, vt[i].e_mwe);
      chk32($sformatf("row%0d mem_addr", i), a_mem_addr, vt[i].e_maddr);
      chk32($sformatf("row%0d mem_wdata", i), a_mem_wdata, vt[i].e_mwdata);
      chk1 ($sformatf("row%0d c_done", i), a_c_done, vt[i].e_cdone);
      chk1 ($sformatf("row%0d c_err", i), a_c_err, vt[i].e_cerr);
      chk32($sformatf("row%0d c_rdata", i), a_c_rdata, vt[i].e_crdata);
      chk1 ($sformatf("row%0d d_done", i), a_d_done, vt[i].e_ddone);
      chk1 ($sformatf("row%0d d_err", i), a_d_err, vt[i].e_derr);
      chk32($sformatf("row%0d d_rdata", i), a_d_rdata, vt[i].e_drdata);
      chk1 ($sformatf("row%0d stall", i), a_stall, vt[i].e_stall);
      cyc();
    end

    // Watchdog abort: TIMEOUT=4 so mem_req holds for 4 BUSY cycles.
    idle_in(); c_req = 1; c_addr = 32'h44;
    #1;
    chk1("to idle mem_req", a_mem_req, 1'b0);
    chk1("to idle stall", a_stall, 1'b1);
    cyc();
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk1 ($sformatf("to busy%0d mem_req", k), a_mem_req, 1'b1);
      chk32($sformatf("to busy%0d mem_addr", k), a_mem_addr, 32'h44);
      chk1 ($sformatf("to busy%0d c_done", k), a_c_done, 1'b0);
      cyc();
    end
    #1;
    chk1 ("to done c_done", a_c_done, 1'b1);
    chk1 ("to done c_err", a_c_err, 1'b1);
    chk32("to done c_rdata", a_c_rdata, 32'h0);
    chk1 ("to done mem_req", a_mem_req, 1'b0);
    chk1 ("to done stall", a_stall, 1'b0);
    cyc();
    c_req = 0;
    #1;
    chk1("to after c_done", a_c_done, 1'b0);
    chk1("to after c_err", a_c_err, 1'b0);
    cyc();

    // Follow-up read with two wait states must not trip the watchdog.
    c_req = 1; c_addr = 32'h48;
    cyc();
    for (int k = 1; k <= 2; k++) begin
      #1;
      chk1 ($sformatf("fu busy%0d mem_req", k), a_mem_req, 1'b1);
      chk32($sformatf("fu busy%0d mem_addr", k), a_mem_addr, 32'h48);
      cyc();
    end
    mem_ready = 1; mem_rdata = 32'h1234;
    #1;
    chk1("fu ready mem_req", a_mem_req, 1'b1);
    cyc();
    mem_ready = 0; mem_rdata = 0;
    #1;
    chk1 ("fu done c_done", a_c_done, 1'b1);
    chk1 ("fu done c_err", a_c_err, 1'b0);
    chk32("fu done c_rdata", a_c_rdata, 32'h1234);
    cyc();
    c_req = 0;
    #1;
    chk1("fu after c_done", a_c_done, 1'b0);
    cyc();

    // Reset in the middle of a DMA read.
    d_req = 1; d_we = 0; d_addr = 32'h500;
    cyc();
    #1;
    chk1 ("rst busy mem_req", a_mem_req, 1'b1);
    chk32("rst busy mem_addr", a_mem_addr, 32'h500);
    rst = 1;
    cyc();
    rst = 0; d_req = 0;
    #1;
    chk1 ("rst after mem_req", a_mem_req, 1'b0);
    chk1 ("rst after d_done", a_d_done, 1'b0);
    chk32("rst after mem_addr", a_mem_addr, 32'h0);
    chk32("rst after d_rdata", a_d_rdata, 32'h0);
    chk32("rst after c_rdata", a_c_rdata, 32'h0);
    cyc();
    #1;
    chk1("rst idle d_done", a_d_done, 1'b0);
    chk1("rst idle mem_req", a_mem_req, 1'b0);
    cyc();

    // Continuous tie, zero-wait memory: u_a alternates from CPU, u_b always CPU.
    c_req = 1; d_req = 1; c_addr = 32'h10; d_addr = 32'h20;
    mem_ready = 1; mem_rdata = 32'hCAFE_0000;
    for (int k = 0; k < 12; k++) begin
      int  txn, ph;
      logic eac, ead;
      txn = k / 3; ph = k % 3;
      eac = (ph == 2) && (txn % 2 == 0);
      ead = (ph == 2) && (txn % 2 == 1);
      #1;
      chk1($sformatf("rr%0d a c_done", k), a_c_done, eac);
      chk1($sformatf("rr%0d a d_done", k), a_d_done, ead);
      chk1($sformatf("rr%0d a stall", k), a_stall, ~eac);
      chk1($sformatf("rr%0d b c_done", k), b_c_done, ph == 2);
      chk1($sformatf("rr%0d b d_done", k), b_d_done, 1'b0);
      if (ph == 1) begin
        chk32($sformatf("rr%0d a mem_addr", k), a_mem_addr, (txn % 2 == 0) ? 32'h10 : 32'h20);
        chk32($sformatf("rr%0d b mem_addr", k), b_mem_addr, 32'h10);
      end
      cyc();
    end
    idle_in();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global time limit: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
